vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL use one clock, `clk`, and one reset, `rst`; `rst` is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- pix_en, in, 1, pixel-rate enable from the frequency divider, high one clk in two
- hsync_n, out, 1, horizontal sync, active-low
- vsync_n, out, 1, vertical sync, active-low
- video_on, out, 1, high inside the visible area
- x, out, 10, current horizontal count
- y, out, 10, current vertical count
- line_end, out, 1, one-clk pulse on line wrap
- frame_start, out, 1, one-clk pulse on frame wrap
- frame_cnt, out, 8, frame counter; present only with VGA_FRAME_CNT_EN

Function
REQ-004 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-005 Counters SHALL be 10-bit: h_cnt and v_cnt.
- Both counters hold when pix_en=0.
REQ-006 h_cnt SHALL advance on a clk edge where pix_en=1.
- h_cnt < H_TOTAL-1: h_cnt increments by 1.
- h_cnt = H_TOTAL-1: h_cnt wraps to 0.
REQ-007 v_cnt SHALL advance only when h_cnt wraps.
- v_cnt < V_TOTAL-1: v_cnt increments by 1.
- v_cnt = V_TOTAL-1: v_cnt wraps to 0.
REQ-008 All outputs SHALL be registered decodes of the counter values held in the same cycle, giving one clk of latency after a counter change.
REQ-009 hsync_n SHALL be 0 when H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751), and 1 otherwise.
REQ-010 vsync_n SHALL be 0 when V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), and 1 otherwise.
REQ-011 video_on SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-012 x SHALL equal h_cnt and y SHALL equal v_cnt, including during blanking.
REQ-013 line_end SHALL be 1 for exactly one clk, in the cycle after a pix_en cycle with h_cnt = H_TOTAL-1.
REQ-014 frame_start SHALL be 1 for exactly one clk, in the cycle after a pix_en cycle with h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
- line_end is also 1 in that same cycle.
REQ-015 When pix_en is held high continuously, counting SHALL continue at one count per clk and the wrap rules SHALL be unchanged.
REQ-016 When pix_en is 0, no pulse SHALL be generated; line_end and frame_start SHALL be 0 in the following cycle.

Reset
REQ-017 While rst=1 at a clk edge, the block SHALL force the following values, and rst SHALL take priority over pix_en:
- h_cnt=0, v_cnt=0
- hsync_n=1, vsync_n=1
- video_on=0, x=0, y=0
- line_end=0, frame_start=0
- frame_cnt=0
REQ-018 After rst deasserts, the first output update SHALL reflect h_cnt=0, v_cnt=0.
- video_on=1, hsync_n=1, vsync_n=1.
REQ-019 Reset asserted mid-line or mid-frame SHALL abandon the frame with no pulse; counting restarts from 0,0.

Configuration
REQ-020 With macro VGA_FRAME_CNT_EN defined:
- The block SHALL provide the 8-bit frame_cnt output.
- frame_cnt SHALL increment, modulo 256, in the same cycle frame_start is asserted.
REQ-021 Without VGA_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- rst=1 for 3 clk, pix_en toggling -> all outputs at reset values; one clk after release: video_on=1, x=0, y=0.
- pix_en alternating 1/0 for one full line -> hsync_n=0 for exactly 96 pix_en counts (x=656..751); line_end pulses once, after x=799; y goes 0->1.
- Run to y=489, then through y=492 -> vsync_n=0 only while y=490 and y=491.
- Run a full frame of 420000 pix_en counts -> frame_start pulses once, one clk after x=799, y=524; x and y return to 0; with VGA_FRAME_CNT_EN, frame_cnt goes 0->1.
- Assert rst at x=300, y=200 -> next clk: x=0, y=0; no line_end or frame_start pulse.
- Hold pix_en=0 for 50 clk at x=639 -> x holds at 639 and video_on stays 1; on the next pix_en: x=640, video_on=0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: 10-bit pixel/line counters with registered sync, blanking and position decodes.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output and its register.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_end,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_cnt_nxt;
  logic [9:0] v_cnt_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_active;
  logic       vs_active;
  logic       visible;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    h_cnt_nxt = h_cnt;
    v_cnt_nxt = v_cnt;
    if (pix_en) begin
      if (h_wrap) begin
        h_cnt_nxt = '0;
        v_cnt_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt_nxt = h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt_nxt;
      v_cnt <= v_cnt_nxt;
    end
  end

  assign hs_active = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
  assign vs_active = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
  assign visible   = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

  // Outputs decode the counters as they stand at this edge, so they trail the counters by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync_n     <= ~hs_active;
      vsync_n     <= ~vs_active;
      video_on    <= visible;
      x           <= h_cnt;
      y           <= v_cnt;
      line_end    <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a scaled-timing instance share stimulus and are
// compared every cycle against a counting model; directed sequences cover the multi-cycle corners.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       le;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
  } tim_t;

  typedef struct {
    logic       r;
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       von;
    logic       le;
  } vec_t;

  // Scaled timing: 25 pixels per line, 13 lines per frame, hsync at 18..20, vsync at 8..9.
  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 4;
  localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam tim_t TL = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TS = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};

  logic clk, rst, pix_en;
  logic hs_l, vs_l, von_l, le_l, fs_l;
  logic hs_s, vs_s, von_s, le_s, fs_s;
  logic [9:0] x_l, y_l, x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc_l, fc_s;
`endif

  vga_sync_gen dut_l (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync_n(hs_l), .vsync_n(vs_l), .video_on(von_l),
    .x(x_l), .y(y_l), .line_end(le_l), .frame_start(fs_l)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_l)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync_n(hs_s), .vsync_n(vs_s), .video_on(von_s),
    .x(x_s), .y(y_s), .line_end(le_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  out_t act_l, act_s, exp_l, exp_s;
`ifdef VGA_FRAME_CNT_EN
  assign act_l = {hs_l, vs_l, von_l, x_l, y_l, le_l, fs_l, fc_l};
  assign act_s = {hs_s, vs_s, von_s, x_s, y_s, le_s, fs_s, fc_s};
`else
  assign act_l = {hs_l, vs_l, von_l, x_l, y_l, le_l, fs_l, 8'd0};
  assign act_s = {hs_s, vs_s, von_s, x_s, y_s, le_s, fs_s, 8'd0};
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Output after an edge, given the number n_pre of pix_en edges seen since reset before it.
  function automatic out_t ref_out(input tim_t t, input int n_pre, input logic pe, input logic r);
    out_t o;
    int ht, vt, ft, h, v;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    ft = ht * vt;
    h  = n_pre % ht;
    v  = (n_pre / ht) % vt;
    o.hs  = !((h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs));
    o.vs  = !((v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs));
    o.von = (h < t.ha) && (v < t.va);
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.le  = pe && (h == ht - 1);
    o.fs  = pe && ((n_pre % ft) == ft - 1);
    o.fc  = 8'(((n_pre + int'(pe)) / ft) % 256);
    if (r) begin
      o    = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
    end
    return o;
  endfunction

  int n_l = 0, n_s = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_l  <= ref_out(TL, 0, 1'b0, 1'b1);
      exp_s  <= ref_out(TS, 0, 1'b0, 1'b1);
      n_l    <= 0;
      n_s    <= 0;
      mon_on <= 1'b1;
    end else begin
      exp_l <= ref_out(TL, n_l, pix_en, 1'b0);
      exp_s <= ref_out(TS, n_s, pix_en, 1'b0);
      n_l   <= n_l + int'(pix_en);
      n_s   <= n_s + int'(pix_en);
    end
  end

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    check({tag, ".hsync_n"},     32'(a.hs),  32'(e.hs));
    check({tag, ".vsync_n"},     32'(a.vs),  32'(e.vs));
    check({tag, ".video_on"},    32'(a.von), 32'(e.von));
    check({tag, ".x"},           32'(a.x),   32'(e.x));
    check({tag, ".y"},           32'(a.y),   32'(e.y));
    check({tag, ".line_end"},    32'(a.le),  32'(e.le));
    check({tag, ".frame_start"}, 32'(a.fs),  32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    check({tag, ".frame_cnt"},   32'(a.fc),  32'(e.fc));
`endif
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      cmp_out("model_l", act_l, exp_l);
      cmp_out("model_s", act_s, exp_s);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic p);
    rst    = r;
    pix_en = p;
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[7];
    int k, lo_cnt, lo_min, lo_max, le_cnt, le_x, fs_cnt, held, bad, after_fs;
    int fs_x, fs_y, fs_le, ax, ay;
    bit saw8, saw9;

    vt[0] = '{1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 10'd3, 10'd0, 1'b1, 1'b1, 1'b0};

    rst    = 1'b1;
    pix_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].r, vt[i].p);
      check($sformatf("vec%0d.x", i),        32'(x_s),   32'(vt[i].x));
      check($sformatf("vec%0d.y", i),        32'(y_s),   32'(vt[i].y));
      check($sformatf("vec%0d.hsync_n", i),  32'(hs_s),  32'(vt[i].hs));
      check($sformatf("vec%0d.video_on", i), 32'(von_s), 32'(vt[i].von));
      check($sformatf("vec%0d.line_end", i), 32'(le_s),  32'(vt[i].le));
    end

    // Reset held 3 clk with pix_en toggling, then release.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, logic'(i % 2 == 0));
      check("rst.x", 32'(x_l), 0);
      check("rst.y", 32'(y_l), 0);
      check("rst.hsync_n", 32'(hs_l), 1);
      check("rst.vsync_n", 32'(vs_l), 1);
      check("rst.video_on", 32'(von_l), 0);
      check("rst.line_end", 32'(le_l), 0);
      check("rst.frame_start", 32'(fs_l), 0);
    end
    drive(1'b0, 1'b1);
    check("release.video_on", 32'(von_l), 1);
    check("release.x", 32'(x_l), 0);
    check("release.y", 32'(y_l), 0);

    // One full line with pix_en alternating.
    lo_cnt = 0; lo_min = 1023; lo_max = 0; le_cnt = 0; le_x = -1; fs_cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      drive(1'b0, logic'(i % 2));
      if (!hs_l) begin
        lo_cnt++;
        if (int'(x_l) < lo_min) lo_min = int'(x_l);
        if (int'(x_l) > lo_max) lo_max = int'(x_l);
      end
      if (le_l) begin
        le_cnt++;
        le_x = int'(x_l);
      end
      if (fs_l) fs_cnt++;
    end
    check("line.hsync_low_cycles", 32'(lo_cnt), 192);
    check("line.hsync_first_x", 32'(lo_min), 656);
    check("line.hsync_last_x", 32'(lo_max), 751);
    check("line.line_end_pulses", 32'(le_cnt), 1);
    check("line.line_end_at_x", 32'(le_x), 799);
    check("line.y_after", 32'(y_l), 1);
    check("line.no_frame_start", 32'(fs_cnt), 0);

    // Park the counter at 639 and hold pix_en low.
    k = 0;
    while (x_l != 10'd638 && k < 1000) begin
      drive(1'b0, 1'b1);
      k++;
    end
    check("hold.reach_x638", 32'(x_l), 638);
    held = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0);
      if (x_l == 10'd639 && von_l) held++;
    end
    check("hold.x639_video_on_cycles", 32'(held), 50);
    drive(1'b0, 1'b1);
    check("hold.x_still_639", 32'(x_l), 639);
    drive(1'b0, 1'b0);
    check("hold.x_640", 32'(x_l), 640);
    check("hold.video_off", 32'(von_l), 0);

    // Vertical sync window on the scaled instance, pix_en held high.
    drive(1'b1, 1'b0);
    bad = 0; saw8 = 1'b0; saw9 = 1'b0; k = 0;
    do begin
      drive(1'b0, 1'b1);
      k++;
      if (!vs_s) begin
        if (y_s == 10'd8) saw8 = 1'b1;
        else if (y_s == 10'd9) saw9 = 1'b1;
        else bad++;
      end
    end while (y_s != 10'd10 && k < 600);
    check("vsync.reach_y10", 32'(y_s), 10);
    check("vsync.high_at_y10", 32'(vs_s), 1);
    check("vsync.low_outside_window", 32'(bad), 0);
    check("vsync.low_at_y8", 32'(saw8), 1);
    check("vsync.low_at_y9", 32'(saw9), 1);

    // One full scaled frame (325 counts) from reset.
    drive(1'b1, 1'b0);
    fs_cnt = 0; after_fs = 0; fs_x = -1; fs_y = -1; fs_le = 0; ax = -1; ay = -1;
    for (int i = 0; i < 340; i++) begin
      drive(1'b0, 1'b1);
      if (fs_s) begin
        fs_cnt++;
        fs_x = int'(x_s); fs_y = int'(y_s); fs_le = int'(le_s);
        after_fs = 1;
      end else if (after_fs == 1) begin
        ax = int'(x_s); ay = int'(y_s);
        after_fs = 2;
      end
    end
    check("frame.pulses", 32'(fs_cnt), 1);
    check("frame.at_x", 32'(fs_x), 24);
    check("frame.at_y", 32'(fs_y), 12);
    check("frame.line_end_too", 32'(fs_le), 1);
    check("frame.x_after", 32'(ax), 0);
    check("frame.y_after", 32'(ay), 0);
`ifdef VGA_FRAME_CNT_EN
    check("frame.frame_cnt", 32'(fc_s), 1);
`endif

    // Reset at the last pixel of a mid-frame line must suppress the line_end pulse.
    drive(1'b1, 1'b0);
    k = 0;
    while (!(x_s == 10'd23 && y_s == 10'd4) && k < 400) begin
      drive(1'b0, 1'b1);
      k++;
    end
    check("midrst.reach_x", 32'(x_s), 23);
    check("midrst.reach_y", 32'(y_s), 4);
    drive(1'b1, 1'b1);
    check("midrst.x", 32'(x_s), 0);
    check("midrst.y", 32'(y_s), 0);
    check("midrst.no_line_end", 32'(le_s), 0);
    check("midrst.no_frame_start", 32'(fs_s), 0);
    drive(1'b0, 1'b1);
    check("midrst.restart_x", 32'(x_s), 0);
    check("midrst.restart_video_on", 32'(von_s), 1);
    check("midrst.restart_no_line_end", 32'(le_s), 0);

    // Random pix_en with rare resets, checked by the model.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
